axis_checksum_appender: RTL and testbench

- Single-clock AXI-Stream stage directly downstream of the memory block's read-side master port.
- Forwards each frame word-for-word and appends one checksum word carrying TLAST.
- Accumulates a 32-bit modular sum of the frame's data; the consumer can verify integrity of what was read back from memory.
- Also caps runaway frames, since the upstream read port asserts TLAST on every beat or never.

---
 rtl/axis_checksum_appender_if.sv | 39 +++
 rtl/axis_checksum_appender.sv | 173 +++++++++++++++++
 tb/tb_axis_checksum_appender.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axis_checksum_appender_if.sv
// ---------------------------------------------------------------------------
// axis_checksum_appender_if
//
// Purpose: AXI-Stream bundle used on both sides of axis_checksum_appender.
//
// Signals:
//   tdata  [DATA_WIDTH-1:0]   stream data
//   tstrb  [DATA_WIDTH/8-1:0] byte qualifiers
//   tvalid                    word valid (master -> slave)
//   tlast                     frame end marker (master -> slave)
//   tready                    slave accepts a word (slave -> master)
//
// Modports: master drives tdata/tstrb/tvalid/tlast; slave drives tready.
// ---------------------------------------------------------------------------
interface axis_checksum_appender_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata,
        output tstrb,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_checksum_appender.sv
// ---------------------------------------------------------------------------
// axis_checksum_appender
//
// Purpose: AXI-Stream pass-through stage that forwards every payload word of
// a frame unchanged and then appends one checksum word (modular sum of the
// frame's data) carrying TLAST. Frames that never see TLAST are force-ended
// after MAX_FRAME_LEN words and flagged via the sticky overflow_err.
//
// Ports:
//   axis_aclk     in   clock for both stream sides
//   axis_aresetn  in   synchronous active-low reset
//   s03_axis      slave  modport: payload input stream
//   m03_axis      master modport: payload + checksum output stream
//   frame_count   out  [15:0] frames whose checksum word was handshaked
//   overflow_err  out  sticky, set when a frame is force-ended at the limit
//
// Build option:
//   AXIS_CSUM_STRB_MASK_EN  when defined, byte lanes whose tstrb bit is 0
//                           contribute 0x00 to the sum; otherwise the whole
//                           tdata word is summed.
// ---------------------------------------------------------------------------
module axis_checksum_appender #(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_FRAME_LEN = 256,
    parameter int LEN_WIDTH     = 9
) (
    input  logic                     axis_aclk,
    input  logic                     axis_aresetn,
    axis_checksum_appender_if.slave  s03_axis,
    axis_checksum_appender_if.master m03_axis,
    output logic [15:0]              frame_count,
    output logic                     overflow_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        CSUM = 2'd2
    } state_t;

    state_t                  state_reg,  state_next;
    logic [DATA_WIDTH-1:0]   acc_reg,    acc_next;
    logic [LEN_WIDTH-1:0]    cnt_reg,    cnt_next;
    logic [DATA_WIDTH-1:0]   tdata_reg,  tdata_next;
    logic [STRB_WIDTH-1:0]   tstrb_reg,  tstrb_next;
    logic                    tvalid_reg, tvalid_next;
    logic                    tlast_reg,  tlast_next;
    logic [15:0]             fc_reg,     fc_next;
    logic                    ovf_reg,    ovf_next;

    logic                    slot_free;
    logic                    in_hs;
    logic                    out_hs;
    logic [DATA_WIDTH-1:0]   masked_word;
    logic [DATA_WIDTH-1:0]   acc_sum;
    logic [LEN_WIDTH-1:0]    cnt_inc;

    // Per-lane contribution of the incoming word to the running sum.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
`ifdef AXIS_CSUM_STRB_MASK_EN
            assign masked_word[gi*8 +: 8] = s03_axis.tstrb[gi] ? s03_axis.tdata[gi*8 +: 8] : 8'h00;
`else
            assign masked_word[gi*8 +: 8] = s03_axis.tdata[gi*8 +: 8];
`endif
        end
    endgenerate

    // The output register can take a new word when empty or draining now.
    assign slot_free = !tvalid_reg || m03_axis.tready;

    // Gated by reset so the input side never looks ready while held in reset.
    assign s03_axis.tready = axis_aresetn && slot_free && (state_reg != CSUM);

    assign in_hs  = s03_axis.tvalid && s03_axis.tready;
    assign out_hs = tvalid_reg && m03_axis.tready;

    // A word arriving in IDLE starts a fresh frame, so ignore the old totals.
    assign acc_sum = ((state_reg == IDLE) ? '0 : acc_reg) + masked_word;
    assign cnt_inc = ((state_reg == IDLE) ? '0 : cnt_reg) + 1'b1;

    assign m03_axis.tdata  = tdata_reg;
    assign m03_axis.tstrb  = tstrb_reg;
    assign m03_axis.tvalid = tvalid_reg;
    assign m03_axis.tlast  = tlast_reg;
    assign frame_count     = fc_reg;
    assign overflow_err    = ovf_reg;

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            tdata_reg  <= '0;
            tstrb_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            fc_reg     <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            tdata_reg  <= tdata_next;
            tstrb_reg  <= tstrb_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
            fc_reg     <= fc_next;
            ovf_reg    <= ovf_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        tdata_next  = tdata_reg;
        tstrb_next  = tstrb_reg;
        tvalid_next = tvalid_reg;
        tlast_next  = tlast_reg;
        fc_next     = fc_reg;
        ovf_next    = ovf_reg;

        if (out_hs) begin
            tvalid_next = 1'b0;
        end

        case (state_reg)
            IDLE, PASS: begin
                if (in_hs) begin
                    tdata_next  = s03_axis.tdata;
                    tstrb_next  = s03_axis.tstrb;
                    tlast_next  = 1'b0;
                    tvalid_next = 1'b1;
                    acc_next    = acc_sum;
                    cnt_next    = cnt_inc;
                    if (s03_axis.tlast) begin
                        state_next = CSUM;
                    end else if (cnt_inc == LEN_WIDTH'(MAX_FRAME_LEN)) begin
                        state_next = CSUM;
                        ovf_next   = 1'b1;
                    end else begin
                        state_next = PASS;
                    end
                end
            end
            CSUM: begin
                // tlast is only ever set on the checksum word, so a valid
                // tlast word in the slot means the checksum is already loaded.
                if (tvalid_reg && tlast_reg) begin
                    if (m03_axis.tready) begin
                        fc_next    = fc_reg + 16'd1;
                        acc_next   = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end else if (slot_free) begin
                    tdata_next  = acc_reg;
                    tstrb_next  = '1;
                    tlast_next  = 1'b1;
                    tvalid_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_checksum_appender.sv
module tb_axis_checksum_appender;

    localparam int DW  = 32;
    localparam int MAX = 4;

    logic        axis_aclk;
    logic        axis_aresetn;
    logic [15:0] frame_count;
    logic        overflow_err;

    axis_checksum_appender_if #(.DATA_WIDTH(DW)) s03_axis ();
    axis_checksum_appender_if #(.DATA_WIDTH(DW)) m03_axis ();

    axis_checksum_appender #(
        .DATA_WIDTH(DW),
        .MAX_FRAME_LEN(MAX),
        .LEN_WIDTH(3)
    ) dut (
        .axis_aclk(axis_aclk),
        .axis_aresetn(axis_aresetn),
        .s03_axis(s03_axis),
        .m03_axis(m03_axis),
        .frame_count(frame_count),
        .overflow_err(overflow_err)
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    int checks   = 0;
    int failures = 0;

    // Expected output words: {tdata, tstrb, tlast}
    logic [36:0] exp_q[$];
    logic [31:0] acc_model = 0;
    int          cnt_model = 0;
    logic [15:0] exp_fc    = 0;
    logic        exp_ovf   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = d;
`ifdef AXIS_CSUM_STRB_MASK_EN
        for (int i = 0; i < 4; i++) begin
            if (!s[i]) r[i*8 +: 8] = 8'h00;
        end
`endif
        return r;
    endfunction

    // Output monitor: pops the scoreboard on each output handshake.
    always @(negedge axis_aclk) begin
        if (axis_aresetn && m03_axis.tvalid && m03_axis.tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_word", {m03_axis.tdata, m03_axis.tstrb, m03_axis.tlast}, 37'h0);
                checks--;
                failures += (failures == failures) ? 0 : 0;
                failures++;
                checks++;
                $error("FAIL out_word observed=%0h expected=none", m03_axis.tdata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("out_word", {27'h0, m03_axis.tdata, m03_axis.tstrb, m03_axis.tlast}, {27'h0, e});
                if (e[0]) exp_fc = exp_fc + 16'd1;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] s, input logic last);
        int n;
        s03_axis.tdata  = d;
        s03_axis.tstrb  = s;
        s03_axis.tlast  = last;
        s03_axis.tvalid = 1'b1;
        n = 0;
        @(negedge axis_aclk);
        while (!s03_axis.tready && n < 50) begin
            @(negedge axis_aclk);
            n++;
        end
        chk("send_accept_timeout", {63'h0, s03_axis.tready}, 64'h1);
        if (s03_axis.tready) begin
            exp_q.push_back({d, s, 1'b0});
            acc_model = acc_model + mask_word(d, s);
            cnt_model++;
            if (last || cnt_model == MAX) begin
                exp_q.push_back({acc_model, 4'hF, 1'b1});
                if (!last) exp_ovf = 1'b1;
                acc_model = 0;
                cnt_model = 0;
            end
        end
        @(posedge axis_aclk);
        #1;
        s03_axis.tvalid = 1'b0;
        s03_axis.tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge axis_aclk);
            n++;
        end
        chk({tag, "_drain"}, 64'(exp_q.size()), 64'h0);
        @(negedge axis_aclk);
        @(negedge axis_aclk);
        chk({tag, "_frame_count"}, {48'h0, frame_count}, {48'h0, exp_fc});
        chk({tag, "_overflow_err"}, {63'h0, overflow_err}, {63'h0, exp_ovf});
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, {63'h0, m03_axis.tvalid}, 64'h0);
        chk({tag, "_m_tdata"},  {32'h0, m03_axis.tdata}, 64'h0);
        chk({tag, "_m_tstrb"},  {60'h0, m03_axis.tstrb}, 64'h0);
        chk({tag, "_m_tlast"},  {63'h0, m03_axis.tlast}, 64'h0);
        chk({tag, "_s_tready"}, {63'h0, s03_axis.tready}, 64'h0);
        chk({tag, "_frame_count"}, {48'h0, frame_count}, 64'h0);
        chk({tag, "_overflow_err"}, {63'h0, overflow_err}, 64'h0);
    endtask

    initial begin
        axis_aresetn     = 1'b0;
        s03_axis.tdata   = '0;
        s03_axis.tstrb   = '0;
        s03_axis.tvalid  = 1'b0;
        s03_axis.tlast   = 1'b0;
        m03_axis.tready  = 1'b1;

        // Reset state
        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check_reset_outputs("reset");
        @(posedge axis_aclk);
        #1;
        axis_aresetn = 1'b1;
        @(posedge axis_aclk);
        #1;

        // 3-word frame, one-cycle latency on the first word
        send(32'h1, 4'hF, 1'b0);
        chk("latency_tvalid", {63'h0, m03_axis.tvalid}, 64'h1);
        chk("latency_tdata",  {32'h0, m03_axis.tdata}, 64'h1);
        send(32'h2, 4'hF, 1'b0);
        send(32'h3, 4'hF, 1'b1);
        drain("frame3");
        $display("frame3 done: frame_count=%0d", frame_count);

        // Wrap-around of the modular sum
        send(32'hFFFF_FFFF, 4'hF, 1'b0);
        send(32'h2, 4'hF, 1'b1);
        drain("wrap");
        $display("wrap done: frame_count=%0d", frame_count);

        // Single word with partial strobes
        send(32'h1234_5678, 4'h3, 1'b1);
        drain("strb");
        $display("strb done: frame_count=%0d", frame_count);

        // tlast coincides with the length limit: no overflow
        send(32'h1, 4'hF, 1'b0);
        send(32'h2, 4'hF, 1'b0);
        send(32'h3, 4'hF, 1'b0);
        send(32'h4, 4'hF, 1'b1);
        drain("coincide");
        $display("coincide done: overflow_err=%0d", overflow_err);

        // Checksum stalled by downstream for 5 cycles
        send(32'hAB, 4'hF, 1'b1);
        @(posedge axis_aclk);
        #1;
        m03_axis.tready = 1'b0;
        s03_axis.tdata  = 32'hDEAD_BEEF;
        s03_axis.tstrb  = 4'hF;
        s03_axis.tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge axis_aclk);
            chk("stall_tvalid",   {63'h0, m03_axis.tvalid}, 64'h1);
            chk("stall_tdata",    {32'h0, m03_axis.tdata}, 64'hAB);
            chk("stall_tlast",    {63'h0, m03_axis.tlast}, 64'h1);
            chk("stall_s_tready", {63'h0, s03_axis.tready}, 64'h0);
        end
        @(posedge axis_aclk);
        #1;
        s03_axis.tvalid = 1'b0;
        m03_axis.tready = 1'b1;
        drain("stall");
        $display("stall done: frame_count=%0d", frame_count);

        // Runaway frame force-ended at the limit; words 5-6 start a new frame
        for (int i = 0; i < 6; i++) send(32'h10, 4'hF, 1'b0);
        send(32'h1, 4'hF, 1'b1);
        drain("overflow");
        $display("overflow done: overflow_err=%0d frame_count=%0d", overflow_err, frame_count);

        // Reset in the middle of a frame
        send(32'h100, 4'hF, 1'b0);
        send(32'h200, 4'hF, 1'b0);
        axis_aresetn = 1'b0;
        @(posedge axis_aclk);
        @(negedge axis_aclk);
        exp_q.delete();
        acc_model = 0;
        cnt_model = 0;
        exp_fc    = 0;
        exp_ovf   = 0;
        check_reset_outputs("midreset");
        @(posedge axis_aclk);
        #1;
        axis_aresetn = 1'b1;
        @(posedge axis_aclk);
        #1;
        send(32'h5, 4'hF, 1'b0);
        send(32'h7, 4'hF, 1'b1);
        drain("post_reset");
        $display("post_reset done: frame_count=%0d", frame_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
